// File: rtl/nco_phase.sv
// nco_phase: phase accumulator for a numerically controlled oscillator.
// Produces a registered 8-bit sine-table address, a carry-out wrap pulse and
// a shadowed tuning word. The tuning word is applied in a phase-continuous way:
// at accumulator wrap, while idle (en=0), or on sync.
// Optional build macro: NCO_DITHER_EN adds LFSR dither to the address
// truncation. The accumulator itself is never dithered.
module nco_phase #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [ACC_W-1:0] ftw,
  input  logic             ftw_load,
  input  logic [7:0]       phase_off,
  input  logic             phase_load,
  input  logic             sync,
  output logic [7:0]       addr,
  output logic             addr_valid,
  output logic             wrap,
  output logic             ftw_pend
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] active_q, active_d;
  logic [ACC_W-1:0] shadow_q, shadow_d;
  logic [7:0]       off_q, off_d;
  logic [7:0]       addr_q, addr_d;
  logic             valid_q;
  logic             wrap_q, wrap_d;
  logic             pend_q, pend_d;
  logic [ACC_W:0]   sum;
  logic             applyNow;
  logic [7:0]       accTop;

`ifdef NCO_DITHER_EN
  logic [15:0]      lfsr_q, lfsr_d;
  logic [ACC_W-9:0] dithLow;
  logic             dithCarry;

  // Dither source: Fibonacci LFSR x^16+x^14+x^13+x^11+1, stepping on enabled cycles.
  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  // Dithered truncation: only the carry into the address byte matters, so the
  // lower sum bits are replaced by an overflow test (a + b >= 2^n  <=>  a > ~b).
  always_comb begin
    dithLow   = (ACC_W-8)'(lfsr_q) << (ACC_W - 24);
    dithCarry = acc_q[ACC_W-9:0] > ~dithLow;
    accTop    = acc_q[ACC_W-1 -: 8] + {7'd0, dithCarry};
  end

  // LFSR state; reseeded to 0xACE1 on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  // Plain truncation of the accumulator to its top byte.
  always_comb begin
    accTop = acc_q[ACC_W-1 -: 8];
  end
`endif

  // Next-state logic: accumulate, detect carry, and manage the shadow tuning word.
  always_comb begin
    sum      = {1'b0, acc_q} + {1'b0, active_q};
    wrap_d   = en & ~sync & sum[ACC_W];
    applyNow = pend_q & ~ftw_load & (wrap_d | ~en | sync);

    acc_d = acc_q;
    if (sync) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum[ACC_W-1:0];
    end

    shadow_d = shadow_q;
    active_d = active_q;
    pend_d   = pend_q;
    if (ftw_load) begin
      shadow_d = ftw;
      pend_d   = 1'b1;
    end else if (applyNow) begin
      active_d = shadow_q;
      pend_d   = 1'b0;
    end

    off_d = off_q;
    if (phase_load) begin
      off_d = phase_off;
    end

    addr_d = accTop + off_q;
  end

  // State and output registers, all cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      active_q <= '0;
      shadow_q <= '0;
      off_q    <= '0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      off_q    <= off_d;
      addr_q   <= addr_d;
      valid_q  <= en;
      wrap_q   <= wrap_d;
      pend_q   <= pend_d;
    end
  end

  assign addr       = addr_q;
  assign addr_valid = valid_q;
  assign wrap       = wrap_q;
  assign ftw_pend   = pend_q;

endmodule

// File: tb/tb_nco_phase.sv
// tb_nco_phase: self-checking bench for nco_phase (default build, ACC_W=32).
// An arithmetic reference model runs alongside the DUT and is compared on every
// falling edge. Directed literal expectations pin the model for ramp, offset,
// sync, phase-continuous switch, load collision and async reset.
module tb_nco_phase;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         sync;
  logic         ftw_load;
  logic [W-1:0] ftw;
  logic         phase_load;
  logic [7:0]   phase_off;
  logic [7:0]   addr;
  logic         addr_valid;
  logic         wrap;
  logic         ftw_pend;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model state, in plain 64-bit integer arithmetic.
  logic [63:0] mAcc = '0;
  logic [63:0] mActive = '0;
  logic [63:0] mShadow = '0;
  logic [63:0] mSum;
  logic [7:0]  mOff = '0;
  logic [7:0]  mAddr = '0;
  logic        mValid = 1'b0;
  logic        mWrap = 1'b0;
  logic        mPend = 1'b0;
  logic        mCarry;
  logic        mApply;

  nco_phase #(.ACC_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ftw        (ftw),
    .ftw_load   (ftw_load),
    .phase_off  (phase_off),
    .phase_load (phase_load),
    .sync       (sync),
    .addr       (addr),
    .addr_valid (addr_valid),
    .wrap       (wrap),
    .ftw_pend   (ftw_pend)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Model helpers: the unbounded sum, its overflow, and the apply rule.
  always_comb begin
    mSum   = mAcc + mActive;
    mCarry = (mSum >= 64'h1_0000_0000);
    mApply = mPend && !ftw_load && ((en && !sync && mCarry) || !en || sync);
  end

  // Model update on each clock edge, cleared asynchronously by reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mAcc    <= '0;
      mActive <= '0;
      mShadow <= '0;
      mOff    <= '0;
      mAddr   <= '0;
      mValid  <= 1'b0;
      mWrap   <= 1'b0;
      mPend   <= 1'b0;
    end else begin
      mAddr  <= 8'(((mAcc >> (W - 8)) + 64'(mOff)) % 256);
      mValid <= en;
      mWrap  <= en && !sync && mCarry;
      if (sync) mAcc <= '0;
      else if (en) mAcc <= mSum % 64'h1_0000_0000;
      if (ftw_load) begin
        mShadow <= 64'(ftw);
        mPend   <= 1'b1;
      end else if (mApply) begin
        mActive <= mShadow;
        mPend   <= 1'b0;
      end
      if (phase_load) mOff <= phase_off;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs at a falling edge, then return at the next falling edge.
  task automatic applyStimulus(input logic e, input logic s, input logic fl,
                               input logic [W-1:0] fv, input logic pl,
                               input logic [7:0] pv);
    en = e; sync = s; ftw_load = fl; ftw = fv; phase_load = pl; phase_off = pv;
    @(negedge clk);
  endtask

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    checkOutput("model_addr", int'(addr), int'(mAddr));
    checkOutput("model_addr_valid", int'(addr_valid), int'(mValid));
    checkOutput("model_wrap", int'(wrap), int'(mWrap));
    checkOutput("model_ftw_pend", int'(ftw_pend), int'(mPend));
  end

  int switchExp[8] = '{0, 64, 128, 192, 0, 128, 0, 128};
  int collAddr[6]  = '{0, 128, 0, 128, 0, 16};
  int collPend[6]  = '{0, 1, 1, 0, 0, 0};

  // Directed scenarios followed by a short randomized run.
  initial begin
    rst = 1'b0; en = 1'b0; sync = 1'b0; ftw_load = 1'b0; ftw = '0;
    phase_load = 1'b0; phase_off = '0;
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(0, 0, 1, 32'h0100_0000, 0, 8'd0);
    checkOutput("ramp_pend_set", int'(ftw_pend), 1);
    applyStimulus(0, 0, 0, 32'h0, 0, 8'd0);
    checkOutput("ramp_pend_applied", int'(ftw_pend), 0);
    for (int n = 1; n <= 257; n++) begin
      applyStimulus(1, 0, 0, 32'h0, 0, 8'd0);
      if (n == 1) checkOutput("ramp_first", int'(addr), 0);
      if (n == 2) checkOutput("ramp_second", int'(addr), 1);
      if (n == 255) checkOutput("ramp_no_wrap", int'(wrap), 0);
      if (n == 256) begin
        checkOutput("ramp_last", int'(addr), 255);
        checkOutput("ramp_wrap", int'(wrap), 1);
      end
      if (n == 257) begin
        checkOutput("ramp_rollover", int'(addr), 0);
        checkOutput("ramp_wrap_single", int'(wrap), 0);
      end
    end

    applyStimulus(1, 0, 0, 32'h0, 1, 8'd64);
    checkOutput("offset_strobe_cycle", int'(addr), 1);
    applyStimulus(1, 0, 0, 32'h0, 0, 8'd0);
    checkOutput("offset_applied", int'(addr), 66);
    applyStimulus(1, 0, 0, 32'h0, 0, 8'd0);
    checkOutput("offset_next", int'(addr), 67);

    applyStimulus(1, 1, 0, 32'h0, 0, 8'd0);
    checkOutput("sync_pre_clear", int'(addr), 68);
    checkOutput("sync_no_wrap", int'(wrap), 0);
    applyStimulus(1, 0, 0, 32'h0, 0, 8'd0);
    checkOutput("sync_restart", int'(addr), 64);

    applyStimulus(0, 1, 0, 32'h0, 1, 8'd0);
    applyStimulus(0, 0, 1, 32'h4000_0000, 0, 8'd0);
    applyStimulus(0, 0, 0, 32'h0, 0, 8'd0);
    checkOutput("switch_initial_applied", int'(ftw_pend), 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, (i == 1), 32'h8000_0000, 0, 8'd0);
      checkOutput("switch_addr", int'(addr), switchExp[i]);
      if (i == 2) checkOutput("switch_pend_held", int'(ftw_pend), 1);
      if (i == 3) begin
        checkOutput("switch_wrap", int'(wrap), 1);
        checkOutput("switch_pend_cleared", int'(ftw_pend), 0);
      end
    end

    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, (i == 1), 32'h1000_0000, 0, 8'd0);
      checkOutput("collide_addr", int'(addr), collAddr[i]);
      checkOutput("collide_pend", int'(ftw_pend), collPend[i]);
      if (i == 1) checkOutput("collide_wrap", int'(wrap), 1);
    end

    applyStimulus(1, 0, 1, 32'h2000_0000, 0, 8'd0);
    checkOutput("midrun_addr", int'(addr), 32);
    checkOutput("midrun_pend", int'(ftw_pend), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_addr", int'(addr), 0);
    checkOutput("async_rst_valid", int'(addr_valid), 0);
    checkOutput("async_rst_wrap", int'(wrap), 0);
    checkOutput("async_rst_pend", int'(ftw_pend), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 32'h0, 0, 8'd0);
      checkOutput("post_rst_addr", int'(addr), 0);
      checkOutput("post_rst_pend", int'(ftw_pend), 0);
    end

    for (int i = 0; i < 80; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 7) == 0), W'($urandom()),
                    ($urandom_range(0, 9) == 0), 8'($urandom_range(0, 255)));
    end

    applyStimulus(0, 0, 0, 32'h0, 0, 8'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
